// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: Fetch/Decode/Execute/Writeback sequencing.
// Latency: Moore outputs decoded from the state register; lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles.
// Backpressure: none; the FSM advances every cycle, and a synchronous reset abandons the current instruction.
//
// Ports:
//   i_clk, i_reset            rising-edge clock, synchronous active-high reset
//   i_op, i_funct3, i_funct7b5 instruction fields used for decode
//   i_zero                    ALU zero flag, consulted only in BEQ
//   o_PCWrite .. o_ALUControl datapath enables and mux selects
//   o_illegal                 pulse in DECODE for an unsupported opcode
//   o_instret                 retired-instruction counter
//   o_state                   current state encoding for debug
module multicycle_controller (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_zero,
  output logic        o_PCWrite,
  output logic        o_AdrSrc,
  output logic        o_MemWrite,
  output logic        o_IRWrite,
  output logic [1:0]  o_ResultSrc,
  output logic [1:0]  o_ALUSrcA,
  output logic [1:0]  o_ALUSrcB,
  output logic        o_RegWrite,
  output logic [1:0]  o_ImmSrc,
  output logic [2:0]  o_ALUControl,
  output logic        o_illegal,
  output logic [31:0] o_instret,
  output logic [3:0]  o_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t      r_state;
  logic [31:0] r_instret;

  logic        w_pc_update;
  logic        w_branch;
  logic [1:0]  w_alu_op;

  // State register and retire counter; reset overrides both transition and increment.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTER;
            OP_I:         r_state <= S_EXECUTEI;
            OP_JAL:       r_state <= S_JAL;
            OP_BEQ:       r_state <= S_BEQ;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_JAL:      r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;
      endcase
      // Leaving a final state retires the instruction; the illegal path never reaches one.
      if (r_state == S_MEMWB || r_state == S_MEMWRITE ||
          r_state == S_ALUWB || r_state == S_BEQ)
        r_instret <= r_instret + 32'd1;
    end
  end

  // Moore decode of per-state controls.
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = 2'b00;
    o_AdrSrc    = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_ResultSrc = 2'b00;
    o_ALUSrcA   = 2'b00;
    o_ALUSrcB   = 2'b00;
    o_RegWrite  = 1'b0;
    o_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_IRWrite   = 1'b1;
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b01;
        o_illegal = !(i_op == OP_LW || i_op == OP_SW || i_op == OP_R ||
                      i_op == OP_I || i_op == OP_BEQ || i_op == OP_JAL);
      end
      S_MEMADR: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
      end
      S_MEMREAD: o_AdrSrc = 1'b1;
      S_MEMWB: begin
        o_ResultSrc = 2'b01;
        o_RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_AdrSrc   = 1'b1;
        o_MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        o_ALUSrcA = 2'b10;
        w_alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        w_alu_op  = 2'b10;
      end
      S_ALUWB: o_RegWrite = 1'b1;
      S_JAL: begin
        o_ALUSrcA   = 2'b01;
        o_ALUSrcB   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        o_ALUSrcA = 2'b10;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_PCWrite = w_pc_update | (w_branch & i_zero);

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (i_op)
      OP_SW:   o_ImmSrc = 2'b01;
      OP_BEQ:  o_ImmSrc = 2'b10;
      OP_JAL:  o_ImmSrc = 2'b11;
      default: o_ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; op[5] distinguishes R-type sub from I-type addi.
  always_comb begin
    case (w_alu_op)
      2'b01:   o_ALUControl = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_ALUControl = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_ALUControl = 3'b101;
          3'b110:  o_ALUControl = 3'b011;
          3'b111:  o_ALUControl = 3'b010;
          default: o_ALUControl = 3'b000;
        endcase
      end
      default: o_ALUControl = 3'b000;
    endcase
  end

  assign o_instret = r_instret;
  assign o_state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: randomized instruction stream against a reference model.
// Latency: each instruction expands to its cycle sequence; one expected output record per cycle.
// Backpressure: none; driver pushes expectations, monitor pops and compares every cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        adr;
    logic        memw;
    logic        irw;
    logic [1:0]  rsrc;
    logic [1:0]  asa;
    logic [1:0]  asb;
    logic        regw;
    logic [1:0]  imm;
    logic [2:0]  aluc;
    logic        ill;
    logic [31:0] instret;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;
  int retired = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct3(funct3),
    .i_funct7b5(funct7b5), .i_zero(zero),
    .o_PCWrite(PCWrite), .o_AdrSrc(AdrSrc), .o_MemWrite(MemWrite),
    .o_IRWrite(IRWrite), .o_ResultSrc(ResultSrc), .o_ALUSrcA(ALUSrcA),
    .o_ALUSrcB(ALUSrcB), .o_RegWrite(RegWrite), .o_ImmSrc(ImmSrc),
    .o_ALUControl(ALUControl), .o_illegal(illegal), .o_instret(instret),
    .o_state(state)
  );

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Visited states of a whole instruction, straight from the cycle-count table.
  function automatic void state_seq(input logic [6:0] o, output int s[$]);
    s = {0, 1};
    case (o)
      7'b0000011: s = {0, 1, 2, 3, 4};
      7'b0100011: s = {0, 1, 2, 5};
      7'b0110011: s = {0, 1, 6, 7};
      7'b0010011: s = {0, 1, 8, 7};
      7'b1101111: s = {0, 1, 9, 7};
      7'b1100011: s = {0, 1, 10};
      default:    s = {0, 1};
    endcase
  endfunction

  function automatic obs_t model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input int ret);
    obs_t e;
    int   aluop;
    e = '0;
    aluop = 0;
    e.st = st[3:0];
    case (st)
      0:  begin e.irw = 1; e.asb = 2; e.rsrc = 2; e.pcw = 1; end
      1:  begin e.asa = 1; e.asb = 1; e.ill = !is_legal(o); end
      2:  begin e.asa = 2; e.asb = 1; end
      3:  e.adr = 1;
      4:  begin e.rsrc = 1; e.regw = 1; end
      5:  begin e.adr = 1; e.memw = 1; end
      6:  begin e.asa = 2; aluop = 2; end
      7:  e.regw = 1;
      8:  begin e.asa = 2; e.asb = 1; aluop = 2; end
      9:  begin e.asa = 1; e.asb = 2; e.pcw = 1; end
      10: begin e.asa = 2; aluop = 1; e.pcw = z; end
      default: ;
    endcase
    if (aluop == 1) e.aluc = 3'b001;
    else if (aluop == 2) begin
      if (f3 == 3'b000) e.aluc = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.aluc = 3'b101;
      else if (f3 == 3'b110) e.aluc = 3'b011;
      else if (f3 == 3'b111) e.aluc = 3'b010;
      else e.aluc = 3'b000;
    end
    if (o == 7'b0100011) e.imm = 2'b01;
    else if (o == 7'b1100011) e.imm = 2'b10;
    else if (o == 7'b1101111) e.imm = 2'b11;
    e.instret = ret;
    return e;
  endfunction

  // Drives one instruction; rst_at >= 0 asserts reset during that cycle index and abandons it.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input int zmode, input int rst_at);
    int   s[$];
    logic z;
    state_seq(o, s);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < s.size(); i++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zero = z;
      reset = (i == rst_at);
      exp_q.push_back(model(s[i], o, f3, f7, z, retired));
      @(posedge clk); #1;
      if (i == rst_at) begin
        reset = 1'b0;
        retired = 0;
        return;
      end
    end
    if (is_legal(o)) retired++;
  endtask

  // Monitor: one output record per cycle while expectations are pending.
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal, instret};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_outputs state=%0d actual=%h required=%h", e.st, a, e);
      end
    end
  end

  initial begin
    logic [6:0] ops[6];
    logic [6:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // Directed cases.
    issue(7'b0000011, 3'b000, 1'b0, 2, -1);
    issue(7'b0110011, 3'b000, 1'b1, 2, -1);
    issue(7'b0110011, 3'b000, 1'b0, 2, -1);
    issue(7'b0010011, 3'b000, 1'b1, 2, -1);
    issue(7'b0010011, 3'b010, 1'b0, 2, -1);
    issue(7'b1100011, 3'b000, 1'b0, 1, -1);
    issue(7'b1100011, 3'b000, 1'b0, 0, -1);
    issue(7'b1101111, 3'b000, 1'b0, 2, -1);
    issue(7'b1111111, 3'b000, 1'b0, 2, -1);
    issue(7'b0100011, 3'b000, 1'b0, 2, -1);
    issue(7'b0000011, 3'b000, 1'b0, 2, 3);
    issue(7'b0110011, 3'b110, 1'b0, 2, -1);
    // Randomized stream, with occasional illegal opcodes and mid-instruction resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = 7'($urandom);
        while (is_legal(r)) r = 7'($urandom);
      end else begin
        r = ops[$urandom_range(0, 5)];
      end
      issue(r, 3'($urandom), 1'($urandom),
            2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
